// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared types and sizing helpers for the spm sequencer
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } spm_state_e;

  // Counter must hold 2*width+p_lat-1 without wrapping.
  function automatic int cnt_w(input int width, input int p_lat);
    return $clog2(2 * width + p_lat + 1);
  endfunction

endpackage

// File: rtl/spm_ser_shift.sv
// rtl/spm_ser_shift.sv - serial-in/parallel-out register, new bit enters at the MSB
module spm_ser_shift #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en_i,
  input  logic         sin_i,
  output logic [W-1:0] pout_o
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (shift_en_i) begin
      sh_d = {sin_i, sh_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign pout_o = sh_q;

endmodule

// File: rtl/spm_seq_ctrl.sv
// rtl/spm_seq_ctrl.sv - sequences one operand pair through the serial-parallel multiplier
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0,
  parameter int P_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               spm_rst,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_y,
  input  logic               spm_p
);

  localparam int CW = cnt_w(WIDTH, P_LAT);
  localparam logic [CW-1:0] LAST_C  = CW'(2 * WIDTH + P_LAT - 1);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] PLAT_C  = CW'(P_LAT);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  spm_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] spm_x_q, spm_x_d;
  logic [WIDTH-1:0] y_sh_q, y_sh_d;
  logic [WIDTH-1:0] y_shr;
  logic             shift_en;

  assign y_shr = y_sh_q >> cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    spm_x_d   = spm_x_q;
    y_sh_d    = y_sh_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    spm_y     = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          spm_x_d = in_x;
          y_sh_d  = in_y;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // Upper half of the run extends y with its sign (or zero) bit.
        if (cnt_q < WIDTH_C) begin
          spm_y = y_shr[0];
        end else begin
          spm_y = SIGNED ? y_sh_q[WIDTH-1] : 1'b0;
        end
        shift_en = (cnt_q >= PLAT_C);
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      spm_x_q <= '0;
      y_sh_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spm_x_q <= spm_x_d;
      y_sh_q  <= y_sh_d;
    end
  end

  spm_ser_shift #(
    .W(2 * WIDTH)
  ) u_p_sh (
    .clk       (clk),
    .rst       (rst),
    .shift_en_i(shift_en),
    .sin_i     (spm_p),
    .pout_o    (out_p)
  );

  // Reset also clears the CSA array so an aborted run leaves no residue.
  assign spm_rst = rst | (state_q == CLEAR);
  assign spm_x   = spm_x_q;

endmodule
